// File: rtl/bcd_display_scan_if.sv
// Result-word channel from the BCD adder into the display scanner.
// Handshake: a word {s1, s0, err_in} transfers on the rising clk edge where in_valid && in_ready;
// the master holds in_valid and the word stable until that edge, and in_ready never depends on in_valid.
interface bcd_display_scan_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] s1;
    logic [3:0] s0;
    logic       err_in;

    modport master (output in_valid, s1, s0, err_in, input in_ready);
    modport slave  (input in_valid, s1, s0, err_in, output in_ready);
endinterface

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed 7-segment scanner with a one-entry pending buffer and blinking "Er".
// Define BCD_DISPLAY_LZB_EN to blank a leading zero in the tens slot.
module bcd_display_scan #(
    parameter int CLK_DIV      = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_display_scan_if.slave   bus,
    output logic [6:0]          seg,
    output logic [1:0]          an,
    output logic                shown_err
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_OFF  = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    logic [CW-1:0] cnt;
    logic          idx;
    logic [FW-1:0] fcnt;
    logic          phase;
    logic          pend_full;
    logic [8:0]    pend;
    logic [3:0]    disp_s1;
    logic [3:0]    disp_s0;
    logic          disp_err;
    logic          tick;
    logic          boundary;
    logic          accept;
    logic [6:0]    seg_a;
    logic [1:0]    an_a;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'h3F;
            4'd1:    dec7 = 7'h06;
            4'd2:    dec7 = 7'h5B;
            4'd3:    dec7 = 7'h4F;
            4'd4:    dec7 = 7'h66;
            4'd5:    dec7 = 7'h6D;
            4'd6:    dec7 = 7'h7D;
            4'd7:    dec7 = 7'h07;
            4'd8:    dec7 = 7'h7F;
            4'd9:    dec7 = 7'h6F;
            default: dec7 = 7'h40;
        endcase
    endfunction

    assign tick         = (cnt == CW'(CLK_DIV - 1));
    assign boundary     = tick && idx;
    assign bus.in_ready = !pend_full;
    assign accept       = bus.in_valid && !pend_full;
    assign shown_err    = disp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= 1'b0;
            fcnt  <= '0;
            phase <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= ~idx;
            end
            // Blink timebase runs regardless of what is displayed.
            if (boundary) begin
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    // A word accepted in a boundary cycle lands in pending and waits for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full <= 1'b0;
            pend      <= '0;
            disp_s1   <= '0;
            disp_s0   <= '0;
            disp_err  <= 1'b0;
        end else begin
            if (boundary && pend_full) begin
                {disp_err, disp_s1, disp_s0} <= pend;
                pend_full <= 1'b0;
            end
            if (accept) begin
                pend      <= {bus.err_in, bus.s1, bus.s0};
                pend_full <= 1'b1;
            end
        end
    end

    always_comb begin
        seg_a = 7'h00;
        an_a  = 2'b00;
        if (disp_err) begin
            if (!phase) begin
                seg_a = idx ? 7'h79 : 7'h50;
                an_a  = idx ? 2'b10 : 2'b01;
            end
        end else if (idx) begin
`ifdef BCD_DISPLAY_LZB_EN
            if (disp_s1 != 4'd0) begin
                seg_a = dec7(disp_s1);
                an_a  = 2'b10;
            end
`else
            seg_a = dec7(disp_s1);
            an_a  = 2'b10;
`endif
        end else begin
            seg_a = dec7(disp_s0);
            an_a  = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= (ACTIVE_LOW != 0) ? ~seg_a : seg_a;
            an  <= (ACTIVE_LOW != 0) ? ~an_a : an_a;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: accepted words queue up as expected display contents and are
// released at frame boundaries; each scan slot is compared against the decoded expectation.
module tb_bcd_display_scan;

    localparam int CLK_DIV      = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = 2 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       shown_err;

    bcd_display_scan_if bus();

    bcd_display_scan #(
        .CLK_DIV(CLK_DIV),
        .BLINK_FRAMES(BLINK_FRAMES),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .seg(seg),
        .an(an),
        .shown_err(shown_err)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    logic [8:0] cur_word = '0;
    int         ecnt = 0;
    int         last_n = 0;
    bit         have_edge = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [0:9];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (d > 4'd9) ? 7'h40 : tbl[d];
    endfunction

    // Returns the active-low {an, seg} expected for a slot.
    function automatic logic [8:0] exp_out(input logic [8:0] w, input bit tens, input bit ph);
        logic       e;
        logic [3:0] t;
        logic [3:0] u;
        {e, t, u} = w;
        if (e) begin
            if (ph) return {2'b11, 7'h7F};
            return tens ? {2'b01, ~7'h79} : {2'b10, ~7'h50};
        end
        if (!tens) return {2'b10, ~seg_of(u)};
`ifdef BCD_DISPLAY_LZB_EN
        if (t == 4'd0) return {2'b11, 7'h7F};
`endif
        return {2'b01, ~seg_of(t)};
    endfunction

    // Edge bookkeeping: boundary edges release the pending word, then new acceptances queue.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cur_word  = '0;
            ecnt      = 0;
            have_edge = 1'b0;
        end else begin
            last_n = ecnt;
            if ((ecnt % FRAME) == FRAME - 1 && exp_q.size() > 0) cur_word = exp_q.pop_front();
            if (bus.in_valid && bus.in_ready) exp_q.push_back({bus.err_in, bus.s1, bus.s0});
            ecnt++;
            have_edge = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        bit         tens;
        bit         ph;
        if (rst_n && have_edge) begin
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_q.size() == 0});
            if ((last_n % CLK_DIV) == 1) begin
                tens = ((last_n / CLK_DIV) % 2) == 1;
                ph   = (((last_n / FRAME) / BLINK_FRAMES) % 2) == 1;
                e    = exp_out(cur_word, tens, ph);
                check(tens ? "an_tens" : "an_units", {30'd0, an}, {30'd0, e[8:7]});
                check(tens ? "seg_tens" : "seg_units", {25'd0, seg}, {25'd0, e[6:0]});
                check("shown_err", {31'd0, shown_err}, {31'd0, cur_word[8]});
            end
        end
    end

    task automatic send(input logic [3:0] t, input logic [3:0] u, input logic e);
        bit done;
        done = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.s1       = t;
        bus.s0       = u;
        bus.err_in   = e;
        for (int k = 0; k < 64; k++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.s1       = $urandom_range(0, 15);
        bus.s0       = $urandom_range(0, 15);
        bus.err_in   = $urandom_range(0, 1);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, {30'd0, an}, 32'h3);
        check({tag, "_seg"}, {25'd0, seg}, 32'h7F);
        check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, "_err"}, {31'd0, shown_err}, 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.s1       = '0;
        bus.s0       = '0;
        bus.err_in   = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;
        idle(2 * FRAME);

        send(4'd1, 4'd7, 1'b0);
        send(4'd0, 4'd3, 1'b0);
        idle(3 * FRAME);

        send(4'd5, 4'd12, 1'b1);
        idle(6 * FRAME);

        send(4'd0, 4'd11, 1'b0);
        idle(2 * FRAME);

        for (int i = 0; i < 24; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
            idle($urandom_range(0, 20));
        end
        idle(2 * FRAME);

        send(4'd4, 4'd2, 1'b0);
        idle(2 * FRAME);
        send(4'd9, 4'd9, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        #1 rst_n = 1'b1;
        idle(3 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
